// File: rtl/bdm_cmd_parser_pkg.sv
// rtl/bdm_cmd_parser_pkg.sv - command byte constants, state encoding and opcode decode for the BDM command parser
package bdm_cmd_pkg;

    localparam logic [7:0] CMD_START   = 8'h73;
    localparam logic [7:0] CMD_STOP    = 8'h78;
    localparam logic [7:0] CMD_READ    = 8'h72;
    localparam logic [7:0] CMD_WRITE   = 8'h77;
    localparam logic [7:0] CMD_DELAY   = 8'h64;
    localparam logic [7:0] CMD_ECHO    = 8'h65;
    localparam logic [7:0] CMD_VPP_ON  = 8'h76;
    localparam logic [7:0] CMD_VPP_OFF = 8'h75;

    localparam logic [7:0] RESP_ACK = 8'h2E;
    localparam logic [7:0] RESP_ERR = 8'h3F;
    localparam logic [7:0] RESP_TMO = 8'h21;

    // Bit positions of the do_* strobes in the internal strobe vector
    localparam logic [2:0] STB_READ    = 3'd0;
    localparam logic [2:0] STB_WRITE   = 3'd1;
    localparam logic [2:0] STB_START   = 3'd2;
    localparam logic [2:0] STB_STOP    = 3'd3;
    localparam logic [2:0] STB_DELAY   = 3'd4;
    localparam logic [2:0] STB_ECHO    = 3'd5;
    localparam logic [2:0] STB_VPP_ON  = 3'd6;
    localparam logic [2:0] STB_VPP_OFF = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ARG,
        ST_WAIT_READY,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_SEND_RESP
    } state_t;

    typedef struct packed {
        logic       known;
        logic       needs_arg;
        logic       returns_data;
        logic [2:0] strobe_idx;
    } cmd_info_t;

    function automatic cmd_info_t decode_cmd(input logic [7:0] b);
        cmd_info_t info;
        info = '0;
        info.known = 1'b1;
        case (b)
            CMD_START:   info.strobe_idx = STB_START;
            CMD_STOP:    info.strobe_idx = STB_STOP;
            CMD_VPP_ON:  info.strobe_idx = STB_VPP_ON;
            CMD_VPP_OFF: info.strobe_idx = STB_VPP_OFF;
            CMD_READ: begin
                info.strobe_idx   = STB_READ;
                info.returns_data = 1'b1;
            end
            CMD_WRITE: begin
                info.strobe_idx = STB_WRITE;
                info.needs_arg  = 1'b1;
            end
            CMD_DELAY: begin
                info.strobe_idx = STB_DELAY;
                info.needs_arg  = 1'b1;
            end
            CMD_ECHO: begin
                info.strobe_idx   = STB_ECHO;
                info.needs_arg    = 1'b1;
                info.returns_data = 1'b1;
            end
            default: info.known = 1'b0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/bdm_cmd_parser_if.sv
// rtl/bdm_cmd_parser_if.sv - UART RX/TX byte streams and BDM engine handshake bundle
// master: the parser side (accepts RX, drives TX and BDM strobes)
// slave:  the environment side (UART and BDM engine)
interface bdm_cmd_parser_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;

    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    logic       bdm_do_read;
    logic       bdm_do_write;
    logic       bdm_do_start_mcu;
    logic       bdm_do_stop_mcu;
    logic       bdm_do_delay;
    logic       bdm_do_echo_test;
    logic       bdm_do_enable_vpp;
    logic       bdm_do_disable_vpp;
    logic [7:0] bdm_data_in;
    logic [7:0] bdm_data_out;
    logic       bdm_ready;
    logic       bdm_valid;

    modport master (
        input  rx_valid, rx_data, tx_ready, bdm_data_out, bdm_ready, bdm_valid,
        output rx_ready, tx_valid, tx_data, bdm_data_in,
        output bdm_do_read, bdm_do_write, bdm_do_start_mcu, bdm_do_stop_mcu,
        output bdm_do_delay, bdm_do_echo_test, bdm_do_enable_vpp, bdm_do_disable_vpp
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, bdm_data_out, bdm_ready, bdm_valid,
        input  rx_ready, tx_valid, tx_data, bdm_data_in,
        input  bdm_do_read, bdm_do_write, bdm_do_start_mcu, bdm_do_stop_mcu,
        input  bdm_do_delay, bdm_do_echo_test, bdm_do_enable_vpp, bdm_do_disable_vpp
    );
endinterface

// File: rtl/bdm_cmd_parser.sv
// rtl/bdm_cmd_parser.sv - host UART command front-end for the BDM engine
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   bus         bdm_cmd_parser_if.master: RX byte stream in, TX response stream out,
//               do_* strobes / data_in to the BDM engine, data_out/ready/valid back
//   rx_overrun  sticky flag: a byte arrived while rx_ready was low
//   busy        parser is processing a command (state != IDLE)
module bdm_cmd_parser
    import bdm_cmd_pkg::*;
#(
    parameter bit ACK_EN         = 1'b1,
    parameter int TIMEOUT_CYCLES = 2**24
) (
    input  logic                  clk,
    input  logic                  rst,
    bdm_cmd_parser_if.master      bus,
    output logic                  rx_overrun,
    output logic                  busy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t     state;
    cmd_info_t  dec;
    logic       op_returns;
    logic [2:0] op_idx;
    logic [7:0] stb_q;
    logic [7:0] data_in_q;
    logic       tx_valid_q;
    logic [7:0] tx_data_q;
    logic [CW-1:0] tmo_cnt;
    logic       rx_ready_int;

    always_comb dec = decode_cmd(bus.rx_data);

    // Held low during reset so every output reads 0 while rst is asserted
    assign rx_ready_int = !rst && (state == ST_IDLE || state == ST_GET_ARG);
    assign bus.rx_ready = rx_ready_int;
    assign busy         = (state != ST_IDLE);

    assign bus.tx_valid    = tx_valid_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.bdm_data_in = data_in_q;

    assign bus.bdm_do_read        = stb_q[STB_READ];
    assign bus.bdm_do_write       = stb_q[STB_WRITE];
    assign bus.bdm_do_start_mcu   = stb_q[STB_START];
    assign bus.bdm_do_stop_mcu    = stb_q[STB_STOP];
    assign bus.bdm_do_delay       = stb_q[STB_DELAY];
    assign bus.bdm_do_echo_test   = stb_q[STB_ECHO];
    assign bus.bdm_do_enable_vpp  = stb_q[STB_VPP_ON];
    assign bus.bdm_do_disable_vpp = stb_q[STB_VPP_OFF];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_returns <= 1'b0;
            op_idx     <= '0;
            stb_q      <= '0;
            data_in_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tmo_cnt    <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (bus.rx_valid && !rx_ready_int)
                rx_overrun <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (bus.rx_valid) begin
                        op_returns <= dec.returns_data;
                        op_idx     <= dec.strobe_idx;
                        if (!dec.known) begin
                            tx_data_q  <= RESP_ERR;
                            tx_valid_q <= 1'b1;
                            state      <= ST_SEND_RESP;
                        end else if (dec.needs_arg) begin
                            state <= ST_GET_ARG;
                        end else begin
                            state <= ST_WAIT_READY;
                        end
                    end
                end
                ST_GET_ARG: begin
                    // Argument is taken verbatim, even if it looks like a command
                    if (bus.rx_valid) begin
                        data_in_q <= bus.rx_data;
                        state     <= ST_WAIT_READY;
                    end
                end
                ST_WAIT_READY: begin
                    if (bus.bdm_ready) begin
                        stb_q <= 8'(1) << op_idx;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    stb_q   <= '0;
                    tmo_cnt <= '0;
                    state   <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    // Completion is checked ahead of the timeout; for data commands
                    // bdm_valid is the only completion, so a coincident ready is ignored
                    if (op_returns && bus.bdm_valid) begin
                        tx_data_q  <= bus.bdm_data_out;
                        tx_valid_q <= 1'b1;
                        state      <= ST_SEND_RESP;
                    end else if (!op_returns && bus.bdm_ready) begin
                        if (ACK_EN) begin
                            tx_data_q  <= RESP_ACK;
                            tx_valid_q <= 1'b1;
                            state      <= ST_SEND_RESP;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        tx_data_q  <= RESP_TMO;
                        tx_valid_q <= 1'b1;
                        state      <= ST_SEND_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                ST_SEND_RESP: begin
                    if (bus.tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bdm_cmd_parser.sv
// tb/tb_bdm_cmd_parser.sv - scoreboard bench for bdm_cmd_parser (ACK_EN=1 and ACK_EN=0/short-timeout instances)
module tb_bdm_cmd_parser;
    import bdm_cmd_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       sel;
    logic       rx_valid_d;
    logic [7:0] rx_data_d;
    logic       tx_ready_d;
    int         m_delay;
    logic       m_hang;
    logic [7:0] m_data;

    int checks = 0;
    int errors = 0;
    int tx_seen = 0;
    int stb_seen = 0;
    int tx_extra = 0;
    int stb_extra = 0;

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] arg;
    } stb_exp_t;

    logic [7:0] tq[$];
    stb_exp_t   sq[$];

    bdm_cmd_parser_if ifa ();
    bdm_cmd_parser_if ifb ();

    logic ovr_a, ovr_b, busy_a, busy_b;

    bdm_cmd_parser #(.ACK_EN(1'b1), .TIMEOUT_CYCLES(64)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.master), .rx_overrun(ovr_a), .busy(busy_a)
    );
    bdm_cmd_parser #(.ACK_EN(1'b0), .TIMEOUT_CYCLES(16)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.master), .rx_overrun(ovr_b), .busy(busy_b)
    );

    assign ifa.rx_valid = rx_valid_d && !sel;
    assign ifb.rx_valid = rx_valid_d && sel;
    assign ifa.rx_data  = rx_data_d;
    assign ifb.rx_data  = rx_data_d;
    assign ifa.tx_ready = tx_ready_d;
    assign ifb.tx_ready = tx_ready_d;

    logic [7:0] stb_a, stb_b;
    assign stb_a = {ifa.bdm_do_disable_vpp, ifa.bdm_do_enable_vpp, ifa.bdm_do_echo_test, ifa.bdm_do_delay,
                    ifa.bdm_do_stop_mcu, ifa.bdm_do_start_mcu, ifa.bdm_do_write, ifa.bdm_do_read};
    assign stb_b = {ifb.bdm_do_disable_vpp, ifb.bdm_do_enable_vpp, ifb.bdm_do_echo_test, ifb.bdm_do_delay,
                    ifb.bdm_do_stop_mcu, ifb.bdm_do_start_mcu, ifb.bdm_do_write, ifb.bdm_do_read};

    // BDM engine model: busy for m_delay+1 cycles after a strobe (forever while m_hang),
    // then ready again; read/echo also pulse valid with the result.
    for (genvar g = 0; g < 2; g++) begin : g_mdl
        logic [7:0] s, din, dout_m;
        logic       busy_m, ret_m, echo_m, valid_m, rdy;
        int         cnt;
        assign s   = (g == 0) ? stb_a : stb_b;
        assign din = (g == 0) ? ifa.bdm_data_in : ifb.bdm_data_in;
        assign rdy = !busy_m && (s == 8'h00);
        always @(posedge clk) begin
            valid_m <= 1'b0;
            if (rst) begin
                busy_m <= 1'b0;
                cnt    <= 0;
                ret_m  <= 1'b0;
                echo_m <= 1'b0;
                dout_m <= 8'h00;
            end else if (s != 8'h00) begin
                busy_m <= 1'b1;
                cnt    <= m_delay;
                ret_m  <= s[STB_READ] | s[STB_ECHO];
                echo_m <= s[STB_ECHO];
            end else if (busy_m && !m_hang) begin
                if (cnt == 0) begin
                    busy_m <= 1'b0;
                    if (ret_m) begin
                        valid_m <= 1'b1;
                        dout_m  <= echo_m ? din : m_data;
                    end
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    assign ifa.bdm_ready    = g_mdl[0].rdy;
    assign ifa.bdm_valid    = g_mdl[0].valid_m;
    assign ifa.bdm_data_out = g_mdl[0].dout_m;
    assign ifb.bdm_ready    = g_mdl[1].rdy;
    assign ifb.bdm_valid    = g_mdl[1].valid_m;
    assign ifb.bdm_data_out = g_mdl[1].dout_m;

    logic       obs_rx_ready, obs_tx_valid, obs_busy, obs_ovr;
    logic [7:0] obs_tx_data, obs_stb, obs_din, prev_stb;
    assign obs_rx_ready = sel ? ifb.rx_ready    : ifa.rx_ready;
    assign obs_tx_valid = sel ? ifb.tx_valid    : ifa.tx_valid;
    assign obs_tx_data  = sel ? ifb.tx_data     : ifa.tx_data;
    assign obs_busy     = sel ? busy_b          : busy_a;
    assign obs_ovr      = sel ? ovr_b           : ovr_a;
    assign obs_stb      = sel ? stb_b           : stb_a;
    assign obs_din      = sel ? ifb.bdm_data_in : ifa.bdm_data_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // TX scoreboard: compare each accepted response byte against the expected queue
    always @(negedge clk) begin
        if (!rst && obs_tx_valid && tx_ready_d) begin
            tx_seen++;
            if (tq.size() == 0) begin
                tx_extra++;
                check_eq("tx_unexpected", tx_extra, 0);
            end else begin
                check_eq("tx_byte", obs_tx_data, tq.pop_front());
            end
        end
    end

    // Strobe scoreboard: one-hot, one cycle wide, with the expected argument presented
    always @(negedge clk) begin
        if (!rst && obs_stb != 8'h00) begin
            stb_exp_t e;
            stb_seen++;
            check_eq("stb_width", prev_stb, 0);
            if (sq.size() == 0) begin
                stb_extra++;
                check_eq("stb_unexpected", stb_extra, 0);
            end else begin
                e = sq.pop_front();
                check_eq("stb_onehot", obs_stb, 8'(1) << e.idx);
                check_eq("stb_data_in", obs_din, e.arg);
            end
        end
        prev_stb <= rst ? 8'h00 : obs_stb;
    end

    task automatic push_stb(input logic [2:0] idx, input logic [7:0] arg);
        sq.push_back({idx, arg});
    endtask

    task automatic send_byte(input logic [7:0] b);
        int i;
        for (i = 0; i < 200; i++) begin
            if (obs_rx_ready) break;
            @(posedge clk); #1;
        end
        if (i == 200) check_eq("rx_ready_wait", obs_rx_ready, 1);
        rx_data_d  = b;
        rx_valid_d = 1'b1;
        @(posedge clk); #1;
        rx_valid_d = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!obs_busy && !obs_tx_valid && tq.size() == 0 && sq.size() == 0) break;
        end
        check_eq(tag, i < 3000, 1);
    endtask

    initial begin
        int n, t0, s0, hold_bad;
        rst = 1'b1; sel = 1'b0; rx_valid_d = 1'b0; rx_data_d = 8'h00; tx_ready_d = 1'b1;
        m_delay = 0; m_hang = 1'b0; m_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            #1;
            check_eq("rst_tx_valid", obs_tx_valid, 0);
            check_eq("rst_strobes", obs_stb, 0);
            check_eq("rst_busy", obs_busy, 0);
            check_eq("rst_overrun", obs_ovr, 0);
            check_eq("rst_rx_ready", obs_rx_ready, 0);
            check_eq("rst_data_in", obs_din, 0);
        end
        sel = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_rx_ready", obs_rx_ready, 1);

        // echo with argument A5
        push_stb(STB_ECHO, 8'hA5);
        tq.push_back(8'hA5);
        send_byte(CMD_ECHO);
        send_byte(8'hA5);
        wait_idle("t1_idle");

        // read with slow BDM: no response and busy throughout the wait
        m_delay = 50; m_data = 8'h3C;
        push_stb(STB_READ, 8'hA5);
        tq.push_back(8'h3C);
        send_byte(CMD_READ);
        hold_bad = 0;
        repeat (45) begin
            @(negedge clk);
            if (!obs_busy || obs_tx_valid) hold_bad++;
        end
        check_eq("read_hold", hold_bad, 0);
        wait_idle("t2_idle");
        m_delay = 0;

        // stop with ACK
        push_stb(STB_STOP, 8'hA5);
        tq.push_back(RESP_ACK);
        send_byte(CMD_STOP);
        wait_idle("t3a_idle");

        // stop on the silent instance
        sel = 1'b1;
        t0 = tx_seen;
        push_stb(STB_STOP, 8'h00);
        send_byte(CMD_STOP);
        wait_idle("t3b_idle");
        repeat (5) @(negedge clk);
        check_eq("noack_silent", tx_seen - t0, 0);

        // unknown command, then a byte dropped while the response is stalled
        sel = 1'b0;
        tx_ready_d = 1'b0;
        tq.push_back(RESP_ERR);
        send_byte(8'h51);
        for (n = 0; n < 50 && !obs_tx_valid; n++) @(negedge clk);
        check_eq("err_resp_valid", obs_tx_valid, 1);
        check_eq("err_resp_byte", obs_tx_data, RESP_ERR);
        @(posedge clk); #1;
        rx_data_d = CMD_START; rx_valid_d = 1'b1;
        @(posedge clk); #1;
        rx_valid_d = 1'b0;
        @(negedge clk);
        check_eq("overrun_set", obs_ovr, 1);
        check_eq("resp_still_held", obs_tx_valid, 1);
        tx_ready_d = 1'b1;
        wait_idle("t4_idle");
        repeat (5) @(negedge clk);
        check_eq("overrun_sticky", obs_ovr, 1);
        check_eq("dropped_no_busy", obs_busy, 0);

        // timeout on the 16-cycle instance, then normal operation
        sel = 1'b1;
        m_hang = 1'b1;
        push_stb(STB_START, 8'h00);
        tq.push_back(RESP_TMO);
        send_byte(CMD_START);
        for (n = 0; n < 20 && obs_stb == 8'h00; n++) @(negedge clk);
        check_eq("tmo_strobe_seen", obs_stb != 8'h00, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!obs_tx_valid && n < 100);
        check_eq("tmo_latency", n, 17);
        m_hang = 1'b0;
        wait_idle("t5a_idle");
        t0 = tx_seen; s0 = stb_seen;
        push_stb(STB_VPP_ON, 8'h00);
        send_byte(CMD_VPP_ON);
        wait_idle("t5b_idle");
        repeat (3) @(negedge clk);
        check_eq("vpp_strobe_count", stb_seen - s0, 1);
        check_eq("vpp_silent", tx_seen - t0, 0);

        // reset between write and its argument
        sel = 1'b0;
        send_byte(CMD_WRITE);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst6_busy", obs_busy, 0);
        check_eq("rst6_tx_valid", obs_tx_valid, 0);
        check_eq("rst6_strobes", obs_stb, 0);
        check_eq("rst6_overrun", obs_ovr, 0);
        check_eq("rst6_data_in", obs_din, 0);
        check_eq("rst6_rx_ready", obs_rx_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        push_stb(STB_ECHO, 8'h00);
        tq.push_back(8'h00);
        send_byte(CMD_ECHO);
        send_byte(8'h00);
        wait_idle("t6_idle");

        repeat (5) @(negedge clk);
        check_eq("tx_queue_empty", tq.size(), 0);
        check_eq("stb_queue_empty", sq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
